core0_mini: RTL and testbench

- Simplified uarc core0 stack processor: a multi-cycle, Forth-style machine.
- Fetches byte-coded instructions from byte-addressed program memory and runs them on a data stack, call stack and loop stack.
- Reads and writes word-addressed main memory; exchanges words with other cores over uarc buses.
- Used as the core under uForth bring-up.

---
 rtl/core0_mini.sv | 270 +++++++++++++++++++++++++++
 tb/tb_core0_mini.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core0_mini.sv
// core0_mini: multi-cycle Forth-style stack core with a data stack, a call stack and a loop stack.
// Program and main memories are external synchronous-read RAMs; uarc buses carry words to other cores.
module core0_mini #(
    parameter int WORD_MAG            = 5,
    parameter int UARC_SETS           = 1,
    parameter int TOTAL_BUSES         = 1,
    parameter int PROGRAM_ADDR_WIDTH  = 11,
    parameter int MAIN_ADDR_WIDTH     = 11,
    parameter int ASTACK_DEPTH        = 64,
    parameter int CSTACK_DEPTH        = 16,
    parameter int LSTACK_DEPTH        = 3,
    parameter int CONVEYOR_ADDR_WIDTH = 4,
    localparam int WORD_WIDTH         = 1 << WORD_MAG
) (
    input  logic                                     clk,
    input  logic                                     reset,
    output logic [PROGRAM_ADDR_WIDTH-1:0]            programmem_addr,
    input  logic [8+WORD_WIDTH-1:0]                  programmem_read_value,
    output logic [PROGRAM_ADDR_WIDTH-1:0]            programmem_write_addr,
    output logic [WORD_WIDTH-1:0]                    programmem_write_mask,
    output logic [WORD_WIDTH-1:0]                    programmem_write_value,
    output logic                                     programmem_we,
    output logic [MAIN_ADDR_WIDTH-1:0]               mainmem_read_addr,
    output logic [MAIN_ADDR_WIDTH-1:0]               mainmem_write_addr,
    input  logic [WORD_WIDTH-1:0]                    mainmem_read_value,
    output logic [WORD_WIDTH-1:0]                    mainmem_write_value,
    output logic                                     mainmem_we,
    output logic                                     global_send,
    output logic [WORD_WIDTH-1:0]                    global_data,
    output logic                                     global_kill,
    output logic                                     global_incept,
    output logic                                     global_stream,
    output logic [WORD_WIDTH-1:0]                    global_self_permission,
    output logic [WORD_WIDTH-1:0]                    global_self_address,
    output logic [WORD_WIDTH-1:0]                    global_incept_permission,
    output logic [WORD_WIDTH-1:0]                    global_incept_address,
    output logic [TOTAL_BUSES-1:0]                   sender_enables,
    input  logic [TOTAL_BUSES-1:0]                   sender_send_acks,
    input  logic [TOTAL_BUSES-1:0]                   sender_kill_acks,
    input  logic [TOTAL_BUSES-1:0]                   sender_incept_acks,
    input  logic [TOTAL_BUSES-1:0]                   sender_stream_acks,
    input  logic [TOTAL_BUSES-1:0]                   receiver_enables,
    input  logic [TOTAL_BUSES-1:0]                   receiver_sends,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]   receiver_datas,
    output logic [TOTAL_BUSES-1:0]                   receiver_send_acks,
    input  logic [TOTAL_BUSES-1:0]                   receiver_kills,
    input  logic [TOTAL_BUSES-1:0]                   receiver_incepts,
    input  logic [TOTAL_BUSES-1:0]                   receiver_streams,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]   receiver_self_permissions,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]   receiver_self_addresses,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]   receiver_incept_permissions,
    input  logic [TOTAL_BUSES-1:0][WORD_WIDTH-1:0]   receiver_incept_addresses,
    output logic [TOTAL_BUSES-1:0]                   receiver_kill_acks,
    output logic [TOTAL_BUSES-1:0]                   receiver_incept_acks,
    output logic [TOTAL_BUSES-1:0]                   receiver_stream_acks
);
    localparam int PA = PROGRAM_ADDR_WIDTH;
    localparam int AW = (ASTACK_DEPTH > 1) ? $clog2(ASTACK_DEPTH) : 1;
    localparam int CW = (CSTACK_DEPTH > 1) ? $clog2(CSTACK_DEPTH) : 1;
    localparam int LW = (LSTACK_DEPTH > 1) ? $clog2(LSTACK_DEPTH) : 1;
    localparam int BW = (TOTAL_BUSES > 1) ? $clog2(TOTAL_BUSES) : 1;

    localparam logic [7:0] OP_IMM = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03, OP_AND = 8'h04,
                           OP_OR = 8'h05, OP_XOR = 8'h06, OP_DROP = 8'h07, OP_DUP = 8'h08,
                           OP_SWAP = 8'h09, OP_LOAD = 8'h0A, OP_STORE = 8'h0B, OP_JMP = 8'h0C,
                           OP_JZ = 8'h0D, OP_CALL = 8'h0E, OP_RET = 8'h0F, OP_LPUSH = 8'h10,
                           OP_LNEXT = 8'h11, OP_SEND = 8'h12, OP_RECV = 8'h13,
                           OP_PWRITE = 8'h14, OP_HALT = 8'hFF;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_LOAD, S_SEND, S_RECV, S_HALT} state_t;

    state_t state, next_state;

    logic [PA-1:0]         pc;
    logic [AW-1:0]         sp;
    logic [CW-1:0]         csp;
    logic [LW-1:0]         lsp;
    logic [WORD_WIDTH-1:0] astack [ASTACK_DEPTH];
    logic [PA-1:0]         cstack [CSTACK_DEPTH];
    logic [WORD_WIDTH-1:0] lstack [LSTACK_DEPTH];
    logic [WORD_WIDTH-1:0] send_data;
    logic [BW-1:0]         bus;

    // Stacks are circular at any depth, including non-power-of-two ones.
    function automatic logic [AW-1:0] a_step(input logic [AW-1:0] p, input int d);
        return AW'((int'(p) + d + ASTACK_DEPTH) % ASTACK_DEPTH);
    endfunction
    function automatic logic [CW-1:0] c_step(input logic [CW-1:0] p, input int d);
        return CW'((int'(p) + d + CSTACK_DEPTH) % CSTACK_DEPTH);
    endfunction
    function automatic logic [LW-1:0] l_step(input logic [LW-1:0] p, input int d);
        return LW'((int'(p) + d + LSTACK_DEPTH) % LSTACK_DEPTH);
    endfunction

    logic [7:0]            op;
    logic [WORD_WIDTH-1:0] imm, t_val, n_val, l_dec;
    logic [AW-1:0]         sp_p1, sp_m1, sp_m2;
    logic [CW-1:0]         csp_m1;
    logic [LW-1:0]         lsp_m1;
    logic                  has_imm, bus_ok, rx_hit;

    assign op      = programmem_read_value[7:0];
    assign imm     = programmem_read_value[8 +: WORD_WIDTH];
    assign sp_p1   = a_step(sp, 1);
    assign sp_m1   = a_step(sp, -1);
    assign sp_m2   = a_step(sp, -2);
    assign csp_m1  = c_step(csp, -1);
    assign lsp_m1  = l_step(lsp, -1);
    assign t_val   = astack[sp_m1];
    assign n_val   = astack[sp_m2];
    assign l_dec   = lstack[lsp_m1] - 1'b1;
    assign bus_ok  = imm < WORD_WIDTH'(TOTAL_BUSES);
    assign rx_hit  = receiver_enables[bus] & receiver_sends[bus];
    assign has_imm = (op == OP_IMM) || (op == OP_JMP) || (op == OP_JZ) || (op == OP_CALL) ||
                     (op == OP_LNEXT) || (op == OP_SEND) || (op == OP_RECV);

    assign programmem_addr = pc;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: next_state = S_EXEC;
            S_EXEC: begin
                next_state = S_FETCH;
                case (op)
                    OP_LOAD: next_state = S_LOAD;
                    OP_SEND: if (bus_ok) next_state = S_SEND;
                    OP_RECV: if (bus_ok) next_state = S_RECV;
                    OP_HALT: next_state = S_HALT;
                    default: ;
                endcase
            end
            S_LOAD:  next_state = S_FETCH;
            S_SEND:  if (sender_send_acks[bus]) next_state = S_FETCH;
            S_RECV:  if (rx_hit) next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_FETCH;
        endcase
    end

    // Read address is only driven in EXEC so the RAM's registered data lands in LOAD.
    always_comb begin
        global_send        = 1'b0;
        global_data        = '0;
        sender_enables     = '0;
        receiver_send_acks = '0;
        mainmem_read_addr  = '0;
        case (state)
            S_EXEC: mainmem_read_addr = t_val[MAIN_ADDR_WIDTH-1:0];
            S_SEND: begin
                global_send         = 1'b1;
                global_data         = send_data;
                sender_enables[bus] = 1'b1;
            end
            S_RECV: receiver_send_acks[bus] = rx_hit;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc                     <= '0;
            sp                     <= '0;
            csp                    <= '0;
            lsp                    <= '0;
            send_data              <= '0;
            bus                    <= '0;
            mainmem_we             <= 1'b0;
            mainmem_write_addr     <= '0;
            mainmem_write_value    <= '0;
            programmem_we          <= 1'b0;
            programmem_write_addr  <= '0;
            programmem_write_value <= '0;
            programmem_write_mask  <= '0;
        end else begin
            mainmem_we    <= 1'b0;
            programmem_we <= 1'b0;
            case (state)
                S_EXEC: begin
                    pc <= has_imm ? pc + PA'(5) : pc + PA'(1);
                    case (op)
                        OP_IMM: begin astack[sp] <= imm; sp <= sp_p1; end
                        OP_ADD: begin astack[sp_m2] <= n_val + t_val; sp <= sp_m1; end
                        OP_SUB: begin astack[sp_m2] <= n_val - t_val; sp <= sp_m1; end
                        OP_AND: begin astack[sp_m2] <= n_val & t_val; sp <= sp_m1; end
                        OP_OR:  begin astack[sp_m2] <= n_val | t_val; sp <= sp_m1; end
                        OP_XOR: begin astack[sp_m2] <= n_val ^ t_val; sp <= sp_m1; end
                        OP_DROP: sp <= sp_m1;
                        OP_DUP:  begin astack[sp] <= t_val; sp <= sp_p1; end
                        OP_SWAP: begin astack[sp_m1] <= n_val; astack[sp_m2] <= t_val; end
                        OP_STORE: begin
                            mainmem_we          <= 1'b1;
                            mainmem_write_addr  <= t_val[MAIN_ADDR_WIDTH-1:0];
                            mainmem_write_value <= n_val;
                            sp                  <= sp_m2;
                        end
                        OP_JMP: pc <= imm[PA-1:0];
                        OP_JZ: begin
                            sp <= sp_m1;
                            if (t_val == '0) pc <= imm[PA-1:0];
                        end
                        OP_CALL: begin
                            cstack[csp] <= pc + PA'(5);
                            csp         <= c_step(csp, 1);
                            pc          <= imm[PA-1:0];
                        end
                        OP_RET: begin pc <= cstack[csp_m1]; csp <= csp_m1; end
                        OP_LPUSH: begin
                            lstack[lsp] <= t_val;
                            lsp         <= l_step(lsp, 1);
                            sp          <= sp_m1;
                        end
                        OP_LNEXT: begin
                            if (l_dec != '0) begin
                                lstack[lsp_m1] <= l_dec;
                                pc             <= imm[PA-1:0];
                            end else begin
                                lsp <= lsp_m1;
                            end
                        end
                        OP_SEND: if (bus_ok) begin
                            send_data <= t_val;
                            sp        <= sp_m1;
                            bus       <= imm[BW-1:0];
                        end
                        OP_RECV: if (bus_ok) bus <= imm[BW-1:0];
                        OP_PWRITE: begin
                            programmem_we          <= 1'b1;
                            programmem_write_addr  <= t_val[PA-1:0];
                            programmem_write_value <= n_val;
                            programmem_write_mask  <= '1;
                            sp                     <= sp_m2;
                        end
                        OP_HALT: pc <= pc;
                        default: ;
                    endcase
                end
                S_LOAD: astack[sp_m1] <= mainmem_read_value;
                S_RECV: if (rx_hit) begin
                    astack[sp] <= receiver_datas[bus];
                    sp         <= sp_p1;
                end
                default: ;
            endcase
        end
    end

    assign global_kill              = 1'b0;
    assign global_incept            = 1'b0;
    assign global_stream            = 1'b0;
    assign global_self_permission   = '0;
    assign global_self_address      = '0;
    assign global_incept_permission = '0;
    assign global_incept_address    = '0;
    assign receiver_kill_acks       = '0;
    assign receiver_incept_acks     = '0;
    assign receiver_stream_acks     = '0;

    logic unused_ok;
    assign unused_ok = ^{sender_kill_acks, sender_incept_acks, sender_stream_acks,
                         receiver_kills, receiver_incepts, receiver_streams,
                         receiver_self_permissions, receiver_self_addresses,
                         receiver_incept_permissions, receiver_incept_addresses,
                         UARC_SETS[0], CONVEYOR_ADDR_WIDTH[0]};
endmodule

// File: tb/tb_core0_mini.sv
// Bench for core0_mini: small assembler into a byte program RAM, word main RAM, bus agents,
// ALU table, queue-model random stack programs, and hand sequences for multi-cycle corners.
module tb_core0_mini;
    localparam int W  = 32;
    localparam int NB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [10:0]       programmem_addr, programmem_write_addr;
    logic [39:0]       programmem_read_value;
    logic [W-1:0]      programmem_write_mask, programmem_write_value;
    logic              programmem_we;
    logic [10:0]       mainmem_read_addr, mainmem_write_addr;
    logic [W-1:0]      mainmem_read_value, mainmem_write_value;
    logic              mainmem_we;
    logic              global_send, global_kill, global_incept, global_stream;
    logic [W-1:0]      global_data, global_self_permission, global_self_address;
    logic [W-1:0]      global_incept_permission, global_incept_address;
    logic [NB-1:0]     sender_enables, sender_send_acks, sender_kill_acks, sender_incept_acks;
    logic [NB-1:0]     sender_stream_acks, receiver_enables, receiver_sends, receiver_send_acks;
    logic [NB-1:0]     receiver_kills, receiver_incepts, receiver_streams;
    logic [NB-1:0]     receiver_kill_acks, receiver_incept_acks, receiver_stream_acks;
    logic [NB-1:0][W-1:0] receiver_datas, receiver_self_permissions, receiver_self_addresses;
    logic [NB-1:0][W-1:0] receiver_incept_permissions, receiver_incept_addresses;

    core0_mini dut (
        .clk(clk), .reset(reset),
        .programmem_addr(programmem_addr), .programmem_read_value(programmem_read_value),
        .programmem_write_addr(programmem_write_addr), .programmem_write_mask(programmem_write_mask),
        .programmem_write_value(programmem_write_value), .programmem_we(programmem_we),
        .mainmem_read_addr(mainmem_read_addr), .mainmem_write_addr(mainmem_write_addr),
        .mainmem_read_value(mainmem_read_value), .mainmem_write_value(mainmem_write_value),
        .mainmem_we(mainmem_we), .global_send(global_send), .global_data(global_data),
        .global_kill(global_kill), .global_incept(global_incept), .global_stream(global_stream),
        .global_self_permission(global_self_permission), .global_self_address(global_self_address),
        .global_incept_permission(global_incept_permission),
        .global_incept_address(global_incept_address),
        .sender_enables(sender_enables), .sender_send_acks(sender_send_acks),
        .sender_kill_acks(sender_kill_acks), .sender_incept_acks(sender_incept_acks),
        .sender_stream_acks(sender_stream_acks), .receiver_enables(receiver_enables),
        .receiver_sends(receiver_sends), .receiver_datas(receiver_datas),
        .receiver_send_acks(receiver_send_acks), .receiver_kills(receiver_kills),
        .receiver_incepts(receiver_incepts), .receiver_streams(receiver_streams),
        .receiver_self_permissions(receiver_self_permissions),
        .receiver_self_addresses(receiver_self_addresses),
        .receiver_incept_permissions(receiver_incept_permissions),
        .receiver_incept_addresses(receiver_incept_addresses),
        .receiver_kill_acks(receiver_kill_acks), .receiver_incept_acks(receiver_incept_acks),
        .receiver_stream_acks(receiver_stream_acks)
    );

    // Memories: synchronous read, data valid the cycle after the address.
    logic [7:0]   pmem [2048];
    logic [W-1:0] mmem [2048];
    logic         poke_en = 1'b0;
    logic [10:0]  poke_a;
    logic [W-1:0] poke_d;
    int we_cnt = 0, ack_cnt = 0, send_cnt = 0, pw_cnt = 0;
    logic [10:0]  pw_addr;
    logic [W-1:0] pw_val, pw_mask;

    always @(posedge clk) begin
        programmem_read_value <= {pmem[programmem_addr + 11'd4], pmem[programmem_addr + 11'd3],
                                  pmem[programmem_addr + 11'd2], pmem[programmem_addr + 11'd1],
                                  pmem[programmem_addr]};
        mainmem_read_value <= mmem[mainmem_read_addr];
        if (mainmem_we) mmem[mainmem_write_addr] <= mainmem_write_value;
        if (poke_en)    mmem[poke_a] <= poke_d;
    end

    always @(negedge clk) begin
        if (mainmem_we)            we_cnt++;
        if (receiver_send_acks[0]) ack_cnt++;
        if (global_send)           send_cnt++;
        if (programmem_we) begin
            pw_cnt++;
            pw_addr = programmem_write_addr;
            pw_val  = programmem_write_value;
            pw_mask = programmem_write_mask;
        end
    end

    int n_chk = 0, n_err = 0;
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int apc;
    task automatic op1(input logic [7:0] o);
        pmem[apc] = o;
        apc++;
    endtask
    task automatic opi(input logic [7:0] o, input logic [W-1:0] v);
        pmem[apc] = o;
        for (int i = 0; i < 4; i++) pmem[apc + 1 + i] = v[8*i +: 8];
        apc += 5;
    endtask

    task automatic poke(input logic [10:0] a, input logic [W-1:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic begin_prog();
        @(negedge clk);
        reset = 1'b0;
        sender_send_acks = '0; receiver_enables = '0; receiver_sends = '0; receiver_datas = '0;
        for (int i = 0; i < 2048; i++) pmem[i] = 8'h00;
        apc = 0;
        @(negedge clk);
    endtask

    task automatic go();
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Halted once the fetch address has sat on the halt byte for several cycles.
    task automatic wait_halt(input int haddr, input string name);
        int stable = 0;
        for (int c = 0; c < 3000 && stable < 4; c++) begin
            @(negedge clk);
            if (programmem_addr == 11'(haddr)) stable++;
            else stable = 0;
        end
        chk({"halt_", name}, W'(stable >= 4), 1);
    endtask

    typedef struct {
        string name; logic [7:0] op; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp;
    } alu_vec_t;

    function automatic logic [W-1:0] ref_alu(input int sel, input logic [W-1:0] n, input logic [W-1:0] t);
        case (sel)
            1: return n + t;
            2: return n - t;
            3: return n & t;
            4: return n | t;
            default: return n ^ t;
        endcase
    endfunction

    initial begin
        alu_vec_t vecs[7];
        logic [W-1:0] q[$];
        int w0, a0, s0;
        logic ok;

        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        alu_vec_t vecs[7];
        logic [W-1:0] q[$];
        logic [W-1:0] t, n;
        int w0, a0, s0, sel, hi;
        logic ok;

        reset = 1'b0;
        sender_kill_acks = '0; sender_incept_acks = '0; sender_stream_acks = '0;
        receiver_kills = '0; receiver_incepts = '0; receiver_streams = '0;
        receiver_self_permissions = '0; receiver_self_addresses = '0;
        receiver_incept_permissions = '0; receiver_incept_addresses = '0;
        vecs[0] = '{"add",      8'h02, 32'd2,        32'd3,        32'd5};
        vecs[1] = '{"sub",      8'h03, 32'd10,       32'd3,        32'd7};
        vecs[2] = '{"sub_neg",  8'h03, 32'd3,        32'd10,       32'hFFFF_FFF9};
        vecs[3] = '{"add_wrap", 8'h02, 32'hFFFF_FFFF, 32'd2,       32'd1};
        vecs[4] = '{"and",      8'h04, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
        vecs[5] = '{"or",       8'h05, 32'h0F00_0000, 32'h0000_00F0, 32'h0F00_00F0};
        vecs[6] = '{"xor",      8'h06, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555};

        begin_prog();
        chk("rst_pc",       W'(programmem_addr), 0);
        chk("rst_send",     W'(global_send), 0);
        chk("rst_en",       W'(sender_enables), 0);
        chk("rst_rxack",    W'(receiver_send_acks), 0);
        chk("rst_mwe",      W'(mainmem_we), 0);
        chk("rst_pwe",      W'(programmem_we), 0);
        chk("rst_raddr",    W'(mainmem_read_addr), 0);

        for (int i = 0; i < 7; i++) begin
            begin_prog();
            opi(8'h01, vecs[i].a); opi(8'h01, vecs[i].b); op1(vecs[i].op);
            opi(8'h01, 32'h10); op1(8'h0B); op1(8'hFF);
            w0 = we_cnt;
            go();
            wait_halt(apc - 1, vecs[i].name);
            chk(vecs[i].name, mmem[16], vecs[i].exp);
            if (i == 0) chk("store_we_once", W'(we_cnt - w0), 1);
        end

        // Random stack programs against a queue model of the data stack.
        for (int r = 0; r < 20; r++) begin
            begin_prog();
            q.delete();
            for (int k = 0; k < 12; k++) begin
                sel = $urandom_range(0, 8);
                if ((sel == 6 && q.size() < 1) || (sel != 0 && sel != 6 && q.size() < 2)) sel = 0;
                if ((sel == 0 || sel == 6) && q.size() >= 40) sel = 1;
                case (sel)
                    0: begin t = $urandom; opi(8'h01, t); q.push_back(t); end
                    6: begin op1(8'h08); q.push_back(q[$]); end
                    7: begin op1(8'h09); t = q.pop_back(); n = q.pop_back(); q.push_back(t); q.push_back(n); end
                    8: begin op1(8'h07); void'(q.pop_back()); end
                    default: begin
                        op1(8'(sel + 1)); t = q.pop_back(); n = q.pop_back();
                        q.push_back(ref_alu(sel, n, t));
                    end
                endcase
            end
            opi(8'h01, 32'h30); op1(8'h0B); op1(8'hFF);
            go();
            wait_halt(apc - 1, "rand");
            chk("rand_top", mmem[48], q[$]);
        end

        // Load round trip.
        begin_prog();
        poke(11'h20, 32'hDEAD_BEEF);
        opi(8'h01, 32'h20); op1(8'h0A); opi(8'h01, 32'h21); op1(8'h0B); op1(8'hFF);
        go();
        wait_halt(apc - 1, "load");
        chk("load_rt", mmem[33], 32'hDEAD_BEEF);

        // call / ret / halt with a frozen fetch address.
        begin_prog();
        opi(8'h0E, 32'd20); op1(8'hFF);
        apc = 20;
        opi(8'h01, 32'd7); opi(8'h01, 32'h40); op1(8'h0B); op1(8'h0F);
        go();
        wait_halt(5, "call");
        chk("call_store", mmem[64], 32'd7);
        ok = 1'b1;
        repeat (8) begin @(negedge clk); if (programmem_addr != 11'd5) ok = 1'b0; end
        chk("halt_frozen", W'(ok), 1);

        // Counted loop incrementing a memory counter.
        for (int cnt = 3; cnt >= 1; cnt -= 2) begin
            begin_prog();
            poke(11'h50, 32'd0);
            opi(8'h01, cnt); op1(8'h10);
            opi(8'h01, 32'h50); op1(8'h0A); opi(8'h01, 32'd1); op1(8'h02);
            opi(8'h01, 32'h50); op1(8'h0B); opi(8'h11, 32'd6); op1(8'hFF);
            w0 = we_cnt;
            go();
            wait_halt(29, "loop");
            chk("loop_count", mmem[80], cnt);
            chk("loop_stores", W'(we_cnt - w0), cnt);
        end

        // Send on bus 0, ack held off for several cycles.
        begin_prog();
        opi(8'h01, 32'h55); opi(8'h12, 32'd0); op1(8'hFF);
        go();
        hi = 0;
        for (int c = 0; c < 50 && !global_send; c++) @(negedge clk);
        chk("send_start", W'(global_send), 1);
        ok = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (!global_send || global_data != 32'h55 || sender_enables != 1'b1) ok = 1'b0;
        end
        sender_send_acks = 1'b1;
        @(negedge clk);
        sender_send_acks = 1'b0;
        chk("send_held", W'(ok), 1);
        chk("send_drop", W'({global_send, sender_enables}), 0);
        chk("send_data_clr", global_data, 0);
        wait_halt(10, "send");

        // Reset while stalled in SEND.
        begin_prog();
        opi(8'h01, 32'h55); opi(8'h12, 32'd0); op1(8'hFF);
        go();
        for (int c = 0; c < 50 && !global_send; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_send", W'(global_send), 0);
        chk("rst_mid_pc",   W'(programmem_addr), 0);
        chk("rst_mid_en",   W'(sender_enables), 0);

        // Receive on bus 0.
        begin_prog();
        opi(8'h13, 32'd0); opi(8'h01, 32'h70); op1(8'h0B); op1(8'hFF);
        receiver_enables = 1'b1; receiver_sends = 1'b1; receiver_datas[0] = 32'h99;
        a0 = ack_cnt;
        go();
        wait_halt(apc - 1, "recv");
        chk("recv_data", mmem[112], 32'h99);
        chk("recv_ack_once", W'(ack_cnt - a0), 1);

        // Out-of-range bus index: send/recv do nothing.
        begin_prog();
        opi(8'h01, 32'hAB); opi(8'h12, 32'd1); opi(8'h13, 32'd1);
        opi(8'h01, 32'h74); op1(8'h0B); op1(8'hFF);
        s0 = send_cnt;
        go();
        wait_halt(apc - 1, "bus_nop");
        chk("bus_nop_keep", mmem[116], 32'hAB);
        chk("bus_nop_nosend", W'(send_cnt - s0), 0);

        // Data stack wrap: 65 pushes overwrite the oldest, 64 drops wrap the pointer.
        begin_prog();
        for (int i = 0; i <= 64; i++) opi(8'h01, 32'h1000 + i);
        for (int i = 0; i < 64; i++) op1(8'h07);
        opi(8'h01, 32'h80); op1(8'h0B); op1(8'hFF);
        go();
        wait_halt(apc - 1, "wrap");
        chk("stack_wrap", mmem[128], 32'h1040);

        // Program-memory write port.
        begin_prog();
        opi(8'h01, 32'hCAFE); opi(8'h01, 32'h100); op1(8'h14); op1(8'hFF);
        w0 = pw_cnt;
        go();
        wait_halt(apc - 1, "pwrite");
        chk("pwrite_once", W'(pw_cnt - w0), 1);
        chk("pwrite_addr", W'(pw_addr), 32'h100);
        chk("pwrite_val",  pw_val, 32'hCAFE);
        chk("pwrite_mask", pw_mask, 32'hFFFF_FFFF);
        chk("tied_zero", W'(|{global_kill, global_incept, global_stream, global_self_permission,
                              global_self_address, global_incept_permission, global_incept_address,
                              receiver_kill_acks, receiver_incept_acks, receiver_stream_acks}), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
